lsu_mem_ctrl: RTL

Sequences a single load/store from the LSU execute stage onto the data-memory port and returns load results to writeback. It sits between the LSU ID/EX pipeline register and data memory. It drives the stall that freezes that register while an access is outstanding. It also handles alignment checks, byte-lane steering, and load sign/zero extension.

---
 rtl/lsu_mem_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// Single-access LSU-to-data-memory sequencer.
// It checks alignment, steers byte lanes, stalls ID/EX while an access is outstanding,
// and extends load results for writeback.
module lsu_mem_ctrl #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_nop_in,
    input  logic        is_load_in,
    input  logic        zero_ext_in,
    input  logic [1:0]  size_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic [4:0]  rd_in,
    output logic        stall_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign_err,
    output logic        timeout_err
);

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt;
    logic        op_load;
    logic        op_zext;
    logic [1:0]  op_size;
    logic [1:0]  op_lo;
    logic [4:0]  op_rd;

    logic        size_ok, align_ok, op_legal, op_illegal;
    logic        timeout_hit;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] rdata_sh;
    logic [31:0] load_ext;

    // Decode of the EX-slot op; only consulted in IDLE.
    always_comb begin
        size_ok  = (size_in != 2'b11);
        align_ok = 1'b1;
        if (size_in == 2'b01)
            align_ok = !addr_in[0];
        else if (size_in == 2'b10)
            align_ok = (addr_in[1:0] == 2'b00);
        op_legal   = !is_nop_in && size_ok && align_ok;
        op_illegal = !is_nop_in && !(size_ok && align_ok);
    end

    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = wdata_in;
        case (size_in)
            2'b00: begin
                be_nxt    = 4'b0001 << addr_in[1:0];
                wdata_nxt = {4{wdata_in[7:0]}};
            end
            2'b01: begin
                be_nxt    = addr_in[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{wdata_in[15:0]}};
            end
            default: begin
                be_nxt    = 4'b1111;
                wdata_nxt = wdata_in;
            end
        endcase
    end

    // Move the addressed lane down to bit 0, then extend to the access size.
    always_comb begin
        rdata_sh = mem_rdata >> {op_lo, 3'b000};
        load_ext = rdata_sh;
        case (op_size)
            2'b00:   load_ext = op_zext ? {24'h0, rdata_sh[7:0]}
                                        : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            2'b01:   load_ext = op_zext ? {16'h0, rdata_sh[15:0]}
                                        : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            default: load_ext = rdata_sh;
        endcase
    end

    assign timeout_hit = (wait_cnt == MAX_W - 8'd1);
    assign stall_out   = ((state == IDLE) && op_legal) || (state == BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (op_legal) state_nxt = BUSY;
            BUSY:    if (mem_ack || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'h0;
            mem_be       <= 4'h0;
            mem_wdata    <= 32'h0;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'h0;
            wb_data      <= 32'h0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            wait_cnt     <= 8'h0;
            op_load      <= 1'b0;
            op_zext      <= 1'b0;
            op_size      <= 2'b00;
            op_lo        <= 2'b00;
            op_rd        <= 5'h0;
        end else begin
            misalign_err <= (state == IDLE) && op_illegal;
            timeout_err  <= 1'b0;
            wb_valid     <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_legal) begin
                        mem_req   <= 1'b1;
                        mem_we    <= !is_load_in;
                        mem_addr  <= {addr_in[31:2], 2'b00};
                        mem_be    <= be_nxt;
                        mem_wdata <= wdata_nxt;
                        op_load   <= is_load_in;
                        op_zext   <= zero_ext_in;
                        op_size   <= size_in;
                        op_lo     <= addr_in[1:0];
                        op_rd     <= rd_in;
                        wait_cnt  <= 8'h0;
                    end
                end
                BUSY: begin
                    // Ack wins over a timeout landing on the same cycle.
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        wb_valid <= op_load && (op_rd != 5'h0);
                        wb_rd    <= op_rd;
                        wb_data  <= load_ext;
                    end else if (timeout_hit) begin
                        mem_req     <= 1'b0;
                        mem_we      <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
